// File: rtl/mem_access_unit.sv
// mem_access_unit: turns the multicycle control FSM's memory requests into
// req/ack bus transactions on a unified instruction/data memory, stalls the
// FSM until each access completes, captures ir/mdr and reports sticky errors.
module mem_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_en,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req, r_we, r_irw, r_iord, r_err;
  logic [1:0]         r_code;
  logic [31:0]        r_addr, r_wdata, r_ir, r_mdr;

  logic [31:0]        w_addr;
  logic               w_ill, w_mis, w_tmo;

  assign w_addr = IorD ? alu_out : pc;
  assign w_ill  = IRWrite & (IorD | MemWrite);
  assign w_mis  = (w_addr[1:0] != 2'b00);
  assign w_tmo  = !m_ack && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Stall is combinational so the FSM holds in the very cycle it asks.
  assign stall    = ((r_state == S_IDLE) && acc_en) || (r_state == S_REQ);
  assign done     = (r_state == S_DONE);
  assign m_req    = r_req;
  assign m_we     = r_we;
  assign m_addr   = r_addr;
  assign m_wdata  = r_wdata;
  assign ir       = r_ir;
  assign mdr      = r_mdr;
  assign err      = r_err;
  assign err_code = r_code;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; DONE always returns to IDLE so no access re-triggers.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (acc_en) w_next = (w_ill || w_mis) ? S_DONE : S_REQ;
      S_REQ:  if (m_ack || w_tmo) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus request, capture registers, timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ir    <= '0;
      r_mdr   <= '0;
      r_err   <= 1'b0;
      r_code  <= 2'b00;
      r_cnt   <= '0;
      r_irw   <= 1'b0;
      r_iord  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (acc_en) begin
          if (w_ill) begin
            r_err  <= 1'b1;
            r_code <= 2'b10;
          end else if (w_mis) begin
            r_err  <= 1'b1;
            r_code <= 2'b01;
          end else begin
            r_req   <= 1'b1;
            r_addr  <= w_addr;
            r_we    <= MemWrite;
            r_wdata <= store_data;
            r_cnt   <= '0;
            r_irw   <= IRWrite;
            r_iord  <= IorD;
          end
        end
        S_REQ: begin
          if (m_ack) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            // Reads land in ir for fetches, mdr for data loads; a plain
            // pc read without IRWrite captures nothing.
            if (!r_we) begin
              if (r_irw)       r_ir  <= m_rdata;
              else if (r_iord) r_mdr <= m_rdata;
            end
          end else if (w_tmo) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_err  <= 1'b1;
            r_code <= 2'b11;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, acc_en, IorD, IRWrite, MemWrite, m_ack;
  logic [31:0] pc, alu_out, store_data, m_rdata;
  logic        stall, done, err, m_req, m_we;
  logic [1:0]  err_code;
  logic [31:0] ir, mdr, m_addr, m_wdata;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] exp_ir, exp_mdr;
  logic        exp_err;
  logic [1:0]  exp_code;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .acc_en(acc_en), .IorD(IorD), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .pc(pc), .alu_out(alu_out), .store_data(store_data),
    .stall(stall), .done(done), .ir(ir), .mdr(mdr), .err(err), .err_code(err_code),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  task automatic check_regs(input string tag);
    checks++; if (ir !== exp_ir) begin failures++; $display("FAIL %s ir got=%h exp=%h", tag, ir, exp_ir); end
    checks++; if (mdr !== exp_mdr) begin failures++; $display("FAIL %s mdr got=%h exp=%h", tag, mdr, exp_mdr); end
    checks++; if (err !== exp_err) begin failures++; $display("FAIL %s err got=%b exp=%b", tag, err, exp_err); end
    checks++; if (err_code !== exp_code) begin failures++; $display("FAIL %s err_code got=%b exp=%b", tag, err_code, exp_code); end
  endtask

  // One FSM access; dly = REQ cycles before ack (>= TMO means no ack).
  task automatic run_access(input string tag, input bit iord, irw, mw,
                            input logic [31:0] p, a, sd, rd, input int dly);
    logic [31:0] addr;
    bit ill, mis, tmo, fin;
    int exp_req, exp_cyc, cyc, reqc;
    addr = iord ? a : p;
    ill = irw && (iord || mw);
    mis = (addr[1:0] != 2'b00);
    tmo = (dly >= TMO);
    if (ill || mis) begin exp_req = 0; exp_cyc = 2; end
    else if (tmo) begin exp_req = TMO; exp_cyc = TMO + 2; end
    else begin exp_req = dly + 1; exp_cyc = dly + 3; end

    @(negedge clk);
    acc_en = 1'b1; IorD = iord; IRWrite = irw; MemWrite = mw;
    pc = p; alu_out = a; store_data = sd; m_rdata = rd; m_ack = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL %s stall_req got=%b exp=1", tag, stall); end
    cyc = 1; reqc = 0; fin = 0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) fin = 1;
      else begin
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL %s stall_hold got=%b exp=1", tag, stall); end
        if (m_req === 1'b1) begin
          checks++; if (m_addr !== addr) begin failures++; $display("FAIL %s m_addr got=%h exp=%h", tag, m_addr, addr); end
          checks++; if (m_we !== mw) begin failures++; $display("FAIL %s m_we got=%b exp=%b", tag, m_we, mw); end
          if (mw) begin
            checks++; if (m_wdata !== sd) begin failures++; $display("FAIL %s m_wdata got=%h exp=%h", tag, m_wdata, sd); end
          end
          m_ack = (reqc == dly);
          reqc++;
        end else m_ack = 1'b0;
      end
    end
    m_ack = 1'b0;
    checks++; if (!fin) begin failures++; $display("FAIL %s done_wait got=none exp=pulse", tag); end
    // model update
    if (ill) begin exp_err = 1'b1; exp_code = 2'b10; end
    else if (mis) begin exp_err = 1'b1; exp_code = 2'b01; end
    else if (tmo) begin exp_err = 1'b1; exp_code = 2'b11; end
    else if (!mw) begin
      if (irw) exp_ir = rd;
      else if (iord) exp_mdr = rd;
    end
    checks++; if (cyc !== exp_cyc) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, exp_cyc); end
    checks++; if (reqc !== exp_req) begin failures++; $display("FAIL %s req_cycles got=%0d exp=%0d", tag, reqc, exp_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL %s stall_done got=%b exp=0", tag, stall); end
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL %s m_req_done got=%b exp=0", tag, m_req); end
    check_regs(tag);
    acc_en = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s done_pulse got=%b exp=0", tag, done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL %s stall_idle got=%b exp=0", tag, stall); end
  endtask

  task automatic test_reset();
    rst = 1'b0; acc_en = 1'b0; IorD = 1'b0; IRWrite = 1'b0; MemWrite = 1'b0;
    pc = '0; alu_out = '0; store_data = '0; m_rdata = '0; m_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_ir = '0; exp_mdr = '0; exp_err = 1'b0; exp_code = 2'b00;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset m_req got=%b exp=0", m_req); end
    checks++; if (m_we !== 1'b0) begin failures++; $display("FAIL reset m_we got=%b exp=0", m_we); end
    checks++; if (m_addr !== 32'h0) begin failures++; $display("FAIL reset m_addr got=%h exp=0", m_addr); end
    checks++; if (m_wdata !== 32'h0) begin failures++; $display("FAIL reset m_wdata got=%h exp=0", m_wdata); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset stall got=%b exp=0", stall); end
    check_regs("reset");
  endtask

  task automatic test_directed();
    run_access("fetch", 0, 1, 0, 32'h0000_3000, 32'h0, 32'h0, 32'h8C49_0004, 2);
    run_access("load", 1, 0, 0, 32'h0000_3004, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0);
    run_access("store", 1, 0, 1, 32'h0000_3008, 32'h0000_0020, 32'h1234_5678, 32'hFFFF_FFFF, 1);
    run_access("pcread", 0, 0, 0, 32'h0000_300C, 32'h0, 32'h0, 32'h5555_AAAA, 0);
  endtask

  task automatic test_errors();
    run_access("misalign", 1, 0, 0, 32'h0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0);
    run_access("illegal", 1, 1, 0, 32'h0, 32'h0000_0040, 32'h0, 32'h2222_2222, 0);
    run_access("timeout", 1, 0, 0, 32'h0, 32'h0000_0044, 32'h0, 32'h3333_3333, 99);
    // late ack with no request outstanding must be ignored
    @(negedge clk); m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk); m_ack = 1'b0;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL late_ack m_req got=%b exp=0", m_req); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL late_ack done got=%b exp=0", done); end
    check_regs("late_ack");
    // a clean access afterwards leaves the sticky timeout code in place
    run_access("sticky", 0, 1, 0, 32'h0000_4000, 32'h0, 32'h0, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    acc_en = 1'b1; IorD = 1'b1; IRWrite = 1'b0; MemWrite = 1'b0; alu_out = 32'h80;
    @(negedge clk);
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL midreq m_req_up got=%b exp=1", m_req); end
    rst = 1'b0;
    @(negedge clk);
    acc_en = 1'b0; #1;
    exp_ir = '0; exp_mdr = '0; exp_err = 1'b0; exp_code = 2'b00;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL midreq m_req got=%b exp=0", m_req); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midreq stall got=%b exp=0", stall); end
    rst = 1'b1; m_ack = 1'b1; m_rdata = 32'hCAFE_CAFE;
    @(negedge clk); m_ack = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreq done got=%b exp=0", done); end
    check_regs("midreq");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] p, a;
      p = $urandom & 32'hFFFF_FFFC;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) p[1:0] = 2'($urandom_range(1, 3));
      run_access("rand", 1'($urandom), 1'($urandom), 1'($urandom), p, a,
                 $urandom, $urandom, int'($urandom_range(0, TMO + 1)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
